// File: rtl/raifes_per_interconnect.sv
// AHB-Lite peripheral interconnect: base/mask decode, data-phase response mux,
// ERROR response for unmapped addresses and a wait-state watchdog.
module raifes_per_interconnect #(
    parameter int                          NSLAVES = 4,
    parameter int                          DATA_W  = 32,
    parameter int                          ADDR_W  = 32,
    parameter logic [NSLAVES*ADDR_W-1:0]   BASES   = {32'h80003000, 32'h80002000,
                                                      32'h80001000, 32'h80000000},
    parameter logic [NSLAVES*ADDR_W-1:0]   MASKS   = {4{32'hFFFFF000}},
    parameter int                          TIMEOUT = 255
) (
    input  logic                        clk,
    input  logic                        nRESET,
    input  logic                        per_en,
    input  logic [ADDR_W-1:0]           per_haddr,
    input  logic                        per_hwrite,
    input  logic [2:0]                  per_hsize,
    input  logic [1:0]                  per_htrans,
    input  logic [DATA_W-1:0]           per_hwdata,
    output logic [DATA_W-1:0]           per_hrdata,
    output logic                        per_hready,
    output logic                        per_hresp,
    output logic [NSLAVES-1:0]          s_hsel,
    output logic [ADDR_W-1:0]           s_haddr,
    output logic                        s_hwrite,
    output logic [2:0]                  s_hsize,
    output logic [1:0]                  s_htrans,
    output logic [DATA_W-1:0]           s_hwdata,
    output logic                        s_hreadyin,
    input  logic [NSLAVES*DATA_W-1:0]   s_hrdata,
    input  logic [NSLAVES-1:0]          s_hready,
    input  logic [NSLAVES-1:0]          s_hresp,
    output logic [NSLAVES-1:0]          s_abort,
    input  logic                        err_clr,
    output logic                        err_unmapped,
    output logic                        err_timeout,
    output logic [2:0]                  err_slave
);

    typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

    localparam logic [15:0] TO = 16'(TIMEOUT);

    state_t               r_state;
    logic [2:0]           r_idx;
    logic [15:0]          r_cnt;
    logic [NSLAVES-1:0]   r_abort;
    logic                 r_err_unm;
    logic                 r_err_to;
    logic [2:0]           r_err_slv;

    logic                 w_valid;
    logic                 w_hit;
    logic [2:0]           w_sel_idx;
    logic [NSLAVES-1:0]   w_onehot;
    logic [NSLAVES-1:0]   w_idx_oh;
    logic                 w_rdy;
    logic                 w_resp;
    logic [DATA_W-1:0]    w_rdata;
    logic [15:0]          w_cnt_nxt;
    logic                 w_tmo;
    logic                 w_set_unm;

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        w_hit     = 1'b0;
        w_sel_idx = 3'd0;
        w_onehot  = '0;
        for (int i = NSLAVES-1; i >= 0; i--) begin
            if ((per_haddr & MASKS[i*ADDR_W +: ADDR_W]) == BASES[i*ADDR_W +: ADDR_W]) begin
                w_hit       = 1'b1;
                w_sel_idx   = 3'(i);
                w_onehot    = '0;
                w_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        w_rdy    = 1'b1;
        w_resp   = 1'b0;
        w_rdata  = '0;
        w_idx_oh = '0;
        for (int i = 0; i < NSLAVES; i++) begin
            if (r_idx == 3'(i)) begin
                w_rdy       = s_hready[i];
                w_resp      = s_hresp[i];
                w_rdata     = s_hrdata[i*DATA_W +: DATA_W];
                w_idx_oh[i] = 1'b1;
            end
        end
    end

    always_comb begin
        per_hready = 1'b1;
        per_hresp  = 1'b0;
        per_hrdata = '0;
        case (r_state)
            DATA: begin
                per_hready = w_rdy;
                per_hresp  = w_resp;
                per_hrdata = w_rdata;
            end
            ERR1: begin
                per_hready = 1'b0;
                per_hresp  = 1'b1;
            end
            ERR2:    per_hresp = 1'b1;
            default: ;
        endcase
    end

    assign w_valid   = per_en & per_htrans[1] & per_hready;
    assign w_cnt_nxt = r_cnt + 16'd1;
    assign w_tmo     = (r_state == DATA) & ~w_rdy & (w_cnt_nxt == TO);
    assign w_set_unm = w_valid & ~w_hit;

    assign s_hsel     = w_valid ? w_onehot : '0;
    assign s_haddr    = per_haddr;
    assign s_hwrite   = per_hwrite;
    assign s_hsize    = per_hsize;
    assign s_htrans   = per_htrans;
    assign s_hwdata   = per_hwdata;
    assign s_hreadyin = per_hready;
    assign s_abort    = r_abort;

    assign err_unmapped = r_err_unm;
    assign err_timeout  = r_err_to;
    assign err_slave    = r_err_slv;

    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_state <= IDLE;
            r_idx   <= 3'd0;
            r_cnt   <= 16'd0;
            r_abort <= '0;
        end else begin
            r_abort <= '0;
            case (r_state)
                ERR1: r_state <= ERR2;
                default: begin
                    // IDLE, ERR2 and a completing DATA cycle all accept a new address phase.
                    if (r_state != DATA || w_rdy) begin
                        if (!w_valid) begin
                            r_state <= IDLE;
                        end else if (w_hit) begin
                            r_state <= DATA;
                            r_idx   <= w_sel_idx;
                            r_cnt   <= 16'd0;
                        end else begin
                            r_state <= ERR1;
                        end
                    end else begin
                        r_cnt <= w_cnt_nxt;
                        if (w_tmo) begin
                            r_state <= ERR1;
                            r_abort <= w_idx_oh;
                        end
                    end
                end
            endcase
        end
    end

    // Clear first so a coincident set event takes priority.
    always_ff @(posedge clk or negedge nRESET) begin
        if (!nRESET) begin
            r_err_unm <= 1'b0;
            r_err_to  <= 1'b0;
            r_err_slv <= 3'd0;
        end else begin
            if (err_clr) begin
                r_err_unm <= 1'b0;
                r_err_to  <= 1'b0;
                r_err_slv <= 3'd0;
            end
            if (w_set_unm) r_err_unm <= 1'b1;
            if (w_tmo) begin
                r_err_to  <= 1'b1;
                r_err_slv <= r_idx;
            end
        end
    end

endmodule

// File: tb/tb_raifes_per_interconnect.sv
// Directed bench for raifes_per_interconnect (4 slaves, TIMEOUT=4).
module tb_raifes_per_interconnect;

    logic         clk = 1'b0;
    logic         nRESET = 1'b0;
    logic         per_en = 1'b0;
    logic [31:0]  per_haddr = '0;
    logic         per_hwrite = 1'b0;
    logic [2:0]   per_hsize = 3'd2;
    logic [1:0]   per_htrans = 2'b00;
    logic [31:0]  per_hwdata = '0;
    logic [31:0]  per_hrdata;
    logic         per_hready;
    logic         per_hresp;
    logic [3:0]   s_hsel;
    logic [31:0]  s_haddr;
    logic         s_hwrite;
    logic [2:0]   s_hsize;
    logic [1:0]   s_htrans;
    logic [31:0]  s_hwdata;
    logic         s_hreadyin;
    logic [127:0] s_hrdata = {32'h44, 32'h22, 32'h33, 32'h11};
    logic [3:0]   s_hready = 4'b1111;
    logic [3:0]   s_hresp = 4'b0000;
    logic [3:0]   s_abort;
    logic         err_clr = 1'b0;
    logic         err_unmapped;
    logic         err_timeout;
    logic [2:0]   err_slave;

    int n_chk  = 0;
    int n_fail = 0;

    raifes_per_interconnect #(.NSLAVES(4), .DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .nRESET(nRESET), .per_en(per_en), .per_haddr(per_haddr),
        .per_hwrite(per_hwrite), .per_hsize(per_hsize), .per_htrans(per_htrans),
        .per_hwdata(per_hwdata), .per_hrdata(per_hrdata), .per_hready(per_hready),
        .per_hresp(per_hresp), .s_hsel(s_hsel), .s_haddr(s_haddr), .s_hwrite(s_hwrite),
        .s_hsize(s_hsize), .s_htrans(s_htrans), .s_hwdata(s_hwdata),
        .s_hreadyin(s_hreadyin), .s_hrdata(s_hrdata), .s_hready(s_hready),
        .s_hresp(s_hresp), .s_abort(s_abort), .err_clr(err_clr),
        .err_unmapped(err_unmapped), .err_timeout(err_timeout), .err_slave(err_slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; checks then happen mid-cycle.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic addr(input logic [31:0] a, input logic wr);
        per_en     = 1'b1;
        per_haddr  = a;
        per_hwrite = wr;
        per_htrans = 2'b10;
    endtask

    initial begin
        #12 nRESET = 1'b1;
        cyc();
        #3;
        chk("rst_hready", 32'(per_hready), 32'd1);
        chk("rst_hresp", 32'(per_hresp), 32'd0);
        chk("rst_hrdata", per_hrdata, 32'h0);
        chk("rst_abort", 32'(s_abort), 32'h0);
        chk("rst_errs", {27'd0, err_slave, err_timeout, err_unmapped}, 32'h0);

        // Write 0xA5 to slave 1
        cyc(); addr(32'h80001000, 1'b1); #3;
        chk("wr_hsel", 32'(s_hsel), 32'h2);
        chk("wr_hready_a", 32'(per_hready), 32'd1);
        cyc(); per_htrans = 2'b00; per_hwdata = 32'hA5; #3;
        chk("wr_hwdata", s_hwdata, 32'hA5);
        chk("wr_hready_d", 32'(per_hready), 32'd1);
        chk("wr_hresp_d", 32'(per_hresp), 32'd0);
        chk("wr_hsel_idle", 32'(s_hsel), 32'h0);

        // Back-to-back reads slave 0 then slave 2
        cyc(); addr(32'h80000004, 1'b0); #3;
        chk("rd0_hsel", 32'(s_hsel), 32'h1);
        cyc(); addr(32'h80002008, 1'b0); #3;
        chk("rd0_data", per_hrdata, 32'h11);
        chk("rd0_hready", 32'(per_hready), 32'd1);
        chk("rd2_hsel", 32'(s_hsel), 32'h4);
        cyc(); per_htrans = 2'b00; #3;
        chk("rd2_data", per_hrdata, 32'h22);
        chk("rd2_hready", 32'(per_hready), 32'd1);

        // Unmapped read
        cyc(); addr(32'h80009000, 1'b0); #3;
        chk("unm_hsel", 32'(s_hsel), 32'h0);
        cyc(); per_htrans = 2'b00; #3;
        chk("unm_err1", {30'd0, per_hready, per_hresp}, 32'b01);
        chk("unm_flag", 32'(err_unmapped), 32'd1);
        cyc(); addr(32'h80000000, 1'b0); #3;
        chk("unm_err2", {30'd0, per_hready, per_hresp}, 32'b11);
        chk("unm_next_hsel", 32'(s_hsel), 32'h1);
        cyc(); per_htrans = 2'b00; #3;
        chk("unm_next_data", per_hrdata, 32'h11);
        chk("unm_next_resp", {30'd0, per_hready, per_hresp}, 32'b10);
        cyc(); #3;
        chk("unm_idle", {30'd0, per_hready, per_hresp}, 32'b10);

        // err_clr coincident with a new unmapped access: set wins
        cyc(); addr(32'h90000000, 1'b0); err_clr = 1'b1; #3;
        cyc(); per_htrans = 2'b00; err_clr = 1'b0; #3;
        chk("clr_set_wins", 32'(err_unmapped), 32'd1);
        chk("clr_err1", {30'd0, per_hready, per_hresp}, 32'b01);
        cyc(); #3;
        chk("clr_err2", {30'd0, per_hready, per_hresp}, 32'b11);
        cyc(); err_clr = 1'b1; #3;
        cyc(); err_clr = 1'b0; #3;
        chk("clr_alone", {30'd0, err_timeout, err_unmapped}, 32'h0);

        // Timeout on slave 3
        cyc(); addr(32'h80003000, 1'b0); s_hready = 4'b0111; #3;
        chk("to_hsel", 32'(s_hsel), 32'h8);
        for (int i = 0; i < 4; i++) begin
            cyc(); per_htrans = 2'b00; #3;
            chk($sformatf("to_wait%0d", i), {28'd0, s_abort, 1'b0, 1'b0, per_hready, per_hresp}, 32'b0);
        end
        cyc(); #3;
        chk("to_err1", {30'd0, per_hready, per_hresp}, 32'b01);
        chk("to_abort", 32'(s_abort), 32'h8);
        chk("to_flag", 32'(err_timeout), 32'd1);
        chk("to_slave", 32'(err_slave), 32'd3);
        chk("to_unm_clear", 32'(err_unmapped), 32'd0);
        cyc(); s_hready = 4'b1111; #3;
        chk("to_err2", {30'd0, per_hready, per_hresp}, 32'b11);
        chk("to_abort_off", 32'(s_abort), 32'h0);

        // Async reset during a slave-2 wait state
        cyc(); addr(32'h80002000, 1'b0); s_hready = 4'b1011; #3;
        cyc(); per_htrans = 2'b00; #3;
        chk("rw_wait", 32'(per_hready), 32'd0);
        cyc(); #3;
        chk("rw_wait2", 32'(per_hready), 32'd0);
        #1 nRESET = 1'b0;
        #2;
        chk("rw_async_hready", {30'd0, per_hready, per_hresp}, 32'b10);
        chk("rw_abort", 32'(s_abort), 32'h0);
        chk("rw_flags", 32'(err_timeout), 32'd0);
        s_hready = 4'b1111;
        #1 nRESET = 1'b1;
        cyc(); #3;
        chk("rw_abort_after", 32'(s_abort), 32'h0);
        cyc(); addr(32'h80002000, 1'b0); #3;
        chk("rw_next_hsel", 32'(s_hsel), 32'h4);
        cyc(); per_htrans = 2'b00; #3;
        chk("rw_next_data", per_hrdata, 32'h22);
        chk("rw_next_ready", {30'd0, per_hready, per_hresp}, 32'b10);

        cyc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/raifes_per_interconnect.md
# raifes_per_interconnect

Parametrised AHB-Lite peripheral interconnect between the core's peripheral bus (`per_*`) and up to `NSLAVES` peripherals such as the UART, GPIO and timers. It replaces the fixed single-slave read-data hookup with several additions:
- address decode against per-slave base/mask pairs;
- data-phase multiplexing of `hrdata`/`hready`/`hresp`;
- a proper two-cycle ERROR response for unmapped addresses;
- a wait-state watchdog that terminates hung slaves.

## Interface
- `NSLAVES`, 4, number of slave ports (1..8)
- `DATA_W`, 32, data bus width
- `ADDR_W`, 32, address width
- `BASES`, {0x80003000,0x80002000,0x80001000,0x80000000}, packed `NSLAVES*ADDR_W` base addresses, slave 0 in LSBs
- `MASKS`, {4{0xFFFFF000}}, packed `NSLAVES*ADDR_W` decode masks
- `TIMEOUT`, 255, maximum data-phase wait cycles before forced termination (1..65535)

Ports:
- `clk` in 1 system clock
- `nRESET` in 1 asynchronous active-low reset
- `per_en` in 1 peripheral region enable from the core
- `per_haddr` in ADDR_W address-phase address
- `per_hwrite` in 1 write flag
- `per_hsize` in 3 transfer size
- `per_htrans` in 2 transfer type (bit 1 set = NONSEQ/SEQ)
- `per_hwdata` in DATA_W data-phase write data
- `per_hrdata` out DATA_W data-phase read data to the core
- `per_hready` out 1 transfer done / address-phase accept
- `per_hresp` out 1 1 = ERROR
- `s_hsel` out NSLAVES one-hot address-phase select
- `s_haddr`, `s_hwrite`, `s_hsize`, `s_htrans`, `s_hwdata` out, broadcast copies of the master signals
- `s_hreadyin` out 1 copy of `per_hready`
- `s_hrdata` in NSLAVES*DATA_W packed slave read data
- `s_hready` in NSLAVES per-slave ready
- `s_hresp` in NSLAVES per-slave response
- `s_abort` out NSLAVES one-cycle pulse to a slave terminated by timeout
- `err_clr` in 1 synchronous clear of the sticky error flags
- `err_unmapped` out 1 sticky flag: unmapped access seen
- `err_timeout` out 1 sticky flag: timeout seen
- `err_slave` out 3 index of the last timed-out slave

## Operation
- Valid address phase: `per_en & per_htrans[1] & per_hready`.
- Decode: slave i matches when `(per_haddr & MASKS[i]) == BASES[i]`. If several slaves match, the lowest index wins.
- `s_hsel` is combinational: it carries the one-hot match during a valid address phase and is 0 otherwise.
- FSM states: IDLE, DATA, ERR1, ERR2.
  - IDLE: `per_hready`=1, `per_hresp`=0, `per_hrdata`=0. A valid phase with a match goes to DATA and registers the slave index. A valid phase with no match goes to ERR1.
  - DATA: `per_hrdata`/`per_hready`/`per_hresp` come from the registered slave.
    - When `s_hready[k]`=1, the transfer completes. A new valid address phase in that same cycle stays in DATA, goes to ERR1 or returns to IDLE, as decoded.
    - Otherwise the wait counter increments. When the counter reaches `TIMEOUT`, the FSM goes to ERR1, pulses `s_abort[k]`, sets `err_timeout` and loads `err_slave`=k.
  - ERR1: `per_hready`=0, `per_hresp`=1. Always goes to ERR2.
  - ERR2: `per_hready`=1, `per_hresp`=1. The core may present a new address phase here; it is decoded as in IDLE. Otherwise the FSM returns to IDLE.
- A slave ERROR (`s_hresp[k]`=1) is passed through unmodified and does not set any flag.
- Entering ERR1 from a decode miss sets `err_unmapped`.
- `err_clr` clears both flags and `err_slave`. If a set event occurs in the same cycle, the set wins.
- The wait counter is 16 bits and clears on every entry to DATA.

## Timing
- Reset values: FSM=IDLE, `per_hready`=1, `per_hresp`=0, `per_hrdata`=0, `s_abort`=0, all err outputs 0, counter 0.
- Reset assertion mid-transfer forces IDLE immediately. No abort pulse is generated.
- Zero-wait slave: the address phase is in cycle n and data is returned in cycle n+1 with `per_hready`=1. This gives back-to-back throughput of 1 transfer per cycle.
- Unmapped access: the address phase is in cycle n, ERR1 in n+1, ERR2 in n+2.
- Timeout: the counter reaches `TIMEOUT` after `TIMEOUT` consecutive low-ready cycles in DATA. ERR1 follows in the next cycle. The `s_abort` pulse coincides with ERR1.
- Data-phase output muxes are combinational from the registered index. The index register is the only register on the decode path.

## Test plan
- Write 0xA5 to 0x80001000 with all slaves zero-wait -> `s_hsel`=0010 in the address cycle; slave 1 sees the data next cycle; `per_hready`=1 and `per_hresp`=0 throughout.
- Back-to-back reads 0x80000004 then 0x80002008, with slave 0 returning 0x11 and slave 2 returning 0x22 -> `per_hrdata`=0x11 then 0x22 in consecutive cycles, no stall.
- Read 0x80009000 (unmapped) -> one cycle of hready=0/hresp=1, then one cycle of hready=1/hresp=1; `err_unmapped`=1; a following valid access to slave 0 completes normally.
- Slave 3 holds `s_hready`=0 with `TIMEOUT`=4 -> 4 wait cycles, then ERR1 with `s_abort`=1000 for one cycle, then ERR2; `err_timeout`=1 and `err_slave`=3.
- `err_clr` asserted in the same cycle as a new unmapped access -> `err_unmapped` remains 1. `err_clr` asserted alone -> both flags 0 on the next edge.
- `nRESET` pulsed low during a slave-2 wait state -> `per_hready`=1 and FSM=IDLE asynchronously; no abort pulse; the next access after release works.
